jtag_tap_responder: RTL and testbench
=====================================

Name: jtag_tap_responder

Overview:
- Target-side JTAG TAP (IEEE 1149.1 style), the responder end of the JTAG link the Bus Blaster drives.
- Oversamples TCK/TMS/TDI on the CPLD system clock, runs the 16-state TAP controller and drives TDO.
- Provides IDCODE, BYPASS and one 8-bit USER data register. Used as an on-board loopback target and for self-test of the JTAG path.

Parameters:
- IR_LEN, 4, instruction register width (>=2).
- IDCODE_VAL, 32'h1BB5_0093, value captured by IDCODE (bit0 must be 1).
- SYNC_STAGES, 2, synchronizer flops on TCK/TMS/TDI (>=2).

Ports:
- CLK  in  1  system clock, must be >=4x TCK frequency.
- RST  in  1  synchronous, active-high reset.
- TCK  in  1  JTAG clock, asynchronous to CLK.
- TMS  in  1  JTAG mode select.
- TDI  in  1  JTAG data in.
- TDO  out 1  JTAG data out.
- TDO_OE  out 1  TDO output enable for the pad buffer.
- TAP_STATE  out 4  current TAP state, encoded per package.
- USER_CAPTURE_DATA  in 8  value loaded into the USER DR in Capture-DR.
- USER_UPDATE_DATA  out 8  USER DR value latched in Update-DR.
- USER_UPDATE_STB  out 1  one-CLK pulse when USER_UPDATE_DATA is updated.

Behaviour:
- Input sampling:
  - TCK, TMS and TDI pass through identical SYNC_STAGES flop chains, so all three are aligned.
  - tck_rise / tck_fall are single-CLK pulses from comparing the last synchronized TCK sample with the previous one.
- TCK rising edge:
  - TAP state advances per standard TMS transitions.
  - Capture and shift actions for the current state execute.
  - TDI is sampled.
- TCK falling edge:
  - TDO and TDO_OE update.
  - IR/DR Update actions execute when the state is Update-IR/Update-DR.
- States (16):
  - TLR, RTI.
  - DR path: SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR.
  - IR path: SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR.
- Transitions:
  - TLR: TMS=1 stays, TMS=0 goes to RTI.
  - All other transitions follow the 1149.1 diagram.
  - Five consecutive TMS=1 rising edges reach TLR from any state.
- Instruction register:
  - Capture-IR loads {0...,0,1} (LSBs 2'b01).
  - Shift-IR: shift right, TDI enters the MSB, the LSB goes to TDO.
  - Update-IR copies the shift register to the active IR.
  - TLR forces the active IR to IDCODE.
- Opcodes:
  - IDCODE = 1.
  - USER = 2.
  - BYPASS = all ones.
  - Any other value selects BYPASS.
- Data registers:
  - IDCODE: 32-bit, Capture-DR loads IDCODE_VAL.
  - BYPASS: 1-bit, Capture-DR loads 0.
  - USER: 8-bit, Capture-DR loads USER_CAPTURE_DATA.
  - All DRs shift LSB first, TDI into the MSB.
  - Update-DR with USER active: USER_UPDATE_DATA <= shift register and USER_UPDATE_STB pulses for exactly one CLK.
- TDO:
  - Driven with the selected register's LSB on the falling edge while in ShIR/ShDR.
  - TDO_OE is 1 only in ShIR/ShDR, updated on the falling edge; otherwise TDO_OE=0 and TDO holds.
- Latency: TDO changes SYNC_STAGES+1 CLK after the physical TCK falling edge.
- Reset values: state TLR, IR=IDCODE, TDO=0, TDO_OE=0, USER_UPDATE_DATA=0, USER_UPDATE_STB=0, synchronizers 0.
- Boundary conditions:
  - RST mid-shift: the shift is abandoned immediately and no Update occurs.
  - A tck_rise on the first cycle after RST is not generated (the prior-sample register is reset to 0, and synchronizer contents are 0).
  - Exit from Shift-DR after N≠8 bits with USER active: USER_UPDATE_DATA still takes the full 8-bit shift register contents.

Optional Feature:
- Macro: JTAG_TAP_NTRST_EN.
- Defined:
  - Adds input nTRST (1 bit, active low), synchronized like TCK.
  - Synchronized nTRST=0 forces state TLR and IR=IDCODE on every CLK, regardless of TCK.
  - TDO_OE=0 while asserted.
- Not defined: the port is absent, and reset is via TMS or RST only.

Decomposition:
- Package jtag_tap_pkg:
  - 4-bit TAP state encoding constants.
  - Opcode constants (IDCODE, USER, BYPASS).
  - Next-state function of (state, tms).
- Sub-module jtag_tap_sync: SYNC_STAGES synchronizer plus rise/fall pulse generation for TCK, with TMS/TDI delayed in lockstep.
- Top: TAP FSM, IR, DR mux and TDO logic.

Test Plan:
- Power-on RST, then 5 TCK with TMS=1 → TAP_STATE=TLR, TDO_OE=0 throughout.
- Path TLR→RTI→SelDR→CapDR→ShDR, shift 32 bits with TDI=0 → TDO stream LSB first equals 32'h1BB5_0093; TDO_OE=1 only during the shift.
- Load IR=4'hF, shift DR pattern 8'hA5 plus 1 extra bit → TDO echoes TDI delayed by one TCK, first bit 0.
- Load IR=2 with USER_CAPTURE_DATA=8'h3C, shift in 8'hC3:
  - TDO reads 8'h3C.
  - After UpdDR, USER_UPDATE_DATA=8'hC3 with a single-CLK USER_UPDATE_STB.
- Shift-IR with TDI=0 → first two TDO bits 1,0 (capture 01); loading opcode 4'h7 → DR behaves as BYPASS.
- Assert RST at the 10th bit of a USER shift → state TLR, IR=IDCODE, no USER_UPDATE_STB; with JTAG_TAP_NTRST_EN, the same result via nTRST=0.

Source files
------------

// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: 4-bit state encoding (1149.1 values), opcodes and the TMS next-state function.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    ST_EX2DR   = 4'h0,
    ST_EX1DR   = 4'h1,
    ST_SHDR    = 4'h2,
    ST_PAUSEDR = 4'h3,
    ST_SELIR   = 4'h4,
    ST_UPDDR   = 4'h5,
    ST_CAPDR   = 4'h6,
    ST_SELDR   = 4'h7,
    ST_EX2IR   = 4'h8,
    ST_EX1IR   = 4'h9,
    ST_SHIR    = 4'hA,
    ST_PAUSEIR = 4'hB,
    ST_RTI     = 4'hC,
    ST_UPDIR   = 4'hD,
    ST_CAPIR   = 4'hE,
    ST_TLR     = 4'hF
  } tap_state_e;

  localparam int unsigned OPC_IDCODE = 1;
  localparam int unsigned OPC_USER   = 2;
  // BYPASS is all ones at whatever IR width is used; truncate on use.
  localparam logic [31:0] OPC_BYPASS = 32'hFFFF_FFFF;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      ST_TLR:     n = tms ? ST_TLR   : ST_RTI;
      ST_RTI:     n = tms ? ST_SELDR : ST_RTI;
      ST_SELDR:   n = tms ? ST_SELIR : ST_CAPDR;
      ST_CAPDR:   n = tms ? ST_EX1DR : ST_SHDR;
      ST_SHDR:    n = tms ? ST_EX1DR : ST_SHDR;
      ST_EX1DR:   n = tms ? ST_UPDDR : ST_PAUSEDR;
      ST_PAUSEDR: n = tms ? ST_EX2DR : ST_PAUSEDR;
      ST_EX2DR:   n = tms ? ST_UPDDR : ST_SHDR;
      ST_UPDDR:   n = tms ? ST_SELDR : ST_RTI;
      ST_SELIR:   n = tms ? ST_TLR   : ST_CAPIR;
      ST_CAPIR:   n = tms ? ST_EX1IR : ST_SHIR;
      ST_SHIR:    n = tms ? ST_EX1IR : ST_SHIR;
      ST_EX1IR:   n = tms ? ST_UPDIR : ST_PAUSEIR;
      ST_PAUSEIR: n = tms ? ST_EX2IR : ST_PAUSEIR;
      ST_EX2IR:   n = tms ? ST_UPDIR : ST_SHIR;
      ST_UPDIR:   n = tms ? ST_SELDR : ST_RTI;
      default:    n = ST_TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_sync.sv
// Brings TCK and its companion JTAG inputs into the CLK domain through identical flop chains
// and produces single-cycle TCK rise/fall pulses from the last two synchronized samples.
module jtag_tap_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int DW          = 2
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          tck_in,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          tck_rise,
  output logic          tck_fall
);

  localparam int W = DW + 1;

  // Stage 0 is the newest sample; TCK rides in bit 0 so all inputs stay aligned.
  logic [SYNC_STAGES-1:0][W-1:0] chain_q, chain_d;
  logic tck_prev_q, tck_prev_d;
  logic tck_s;

  assign tck_s    = chain_q[SYNC_STAGES-1][0];
  assign data_out = chain_q[SYNC_STAGES-1][W-1:1];
  assign tck_rise = tck_s & ~tck_prev_q;
  assign tck_fall = ~tck_s & tck_prev_q;

  always_comb begin
    chain_d    = {chain_q[SYNC_STAGES-2:0], {data_in, tck_in}};
    tck_prev_d = tck_s;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      chain_q    <= '0;
      tck_prev_q <= 1'b0;
    end else begin
      chain_q    <= chain_d;
      tck_prev_q <= tck_prev_d;
    end
  end

endmodule

// File: rtl/jtag_tap_responder.sv
// Target-side JTAG TAP with IDCODE, BYPASS and an 8-bit USER register, oversampled on CLK.
// Optional macro JTAG_TAP_NTRST_EN adds an active-low nTRST input that holds the TAP in reset.
module jtag_tap_responder
  import jtag_tap_pkg::*;
#(
  parameter int          IR_LEN      = 4,
  parameter logic [31:0] IDCODE_VAL  = 32'h1BB5_0093,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
`ifdef JTAG_TAP_NTRST_EN
  input  logic       nTRST,
`endif
  input  logic       TCK,
  input  logic       TMS,
  input  logic       TDI,
  output logic       TDO,
  output logic       TDO_OE,
  output logic [3:0] TAP_STATE,
  input  logic [7:0] USER_CAPTURE_DATA,
  output logic [7:0] USER_UPDATE_DATA,
  output logic       USER_UPDATE_STB
);

`ifdef JTAG_TAP_NTRST_EN
  localparam int DW = 3;
`else
  localparam int DW = 2;
`endif

  logic [DW-1:0] sync_in, sync_out;
  logic tck_rise, tck_fall, tms_s, tdi_s;

`ifdef JTAG_TAP_NTRST_EN
  logic ntrst_s;
  assign sync_in = {nTRST, TDI, TMS};
  assign ntrst_s = sync_out[2];
`else
  assign sync_in = {TDI, TMS};
`endif
  assign tms_s = sync_out[0];
  assign tdi_s = sync_out[1];

  jtag_tap_sync #(.SYNC_STAGES(SYNC_STAGES), .DW(DW)) u_sync (
    .clk      (CLK),
    .srst     (RST),
    .tck_in   (TCK),
    .data_in  (sync_in),
    .data_out (sync_out),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  tap_state_e        state_q, state_d;
  logic [IR_LEN-1:0] ir_q, ir_d, ir_sr_q, ir_sr_d;
  logic [31:0]       dr_sr_q, dr_sr_d;
  logic              tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;
  logic [7:0]        user_data_q, user_data_d;
  logic              user_stb_q, user_stb_d;
  logic              is_idcode, is_user;
  logic [4:0]        dr_msb;

  // Any opcode other than IDCODE or USER falls through to BYPASS.
  assign is_idcode = (ir_q == IR_LEN'(OPC_IDCODE));
  assign is_user   = (ir_q == IR_LEN'(OPC_USER));
  assign dr_msb    = is_idcode ? 5'd31 : (is_user ? 5'd7 : 5'd0);

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    ir_sr_d     = ir_sr_q;
    dr_sr_d     = dr_sr_q;
    tdo_d       = tdo_q;
    tdo_oe_d    = tdo_oe_q;
    user_data_d = user_data_q;
    user_stb_d  = 1'b0;

    if (tck_rise) begin
      case (state_q)
        ST_CAPIR: ir_sr_d = IR_LEN'(1);
        ST_SHIR:  ir_sr_d = {tdi_s, ir_sr_q[IR_LEN-1:1]};
        ST_CAPDR: dr_sr_d = is_idcode ? IDCODE_VAL :
                            (is_user ? {24'b0, USER_CAPTURE_DATA} : 32'b0);
        ST_SHDR: begin
          dr_sr_d         = dr_sr_q >> 1;
          dr_sr_d[dr_msb] = tdi_s;
        end
        default: ;
      endcase
      state_d = tap_next(state_q, tms_s);
    end

    if (tck_fall) begin
      tdo_oe_d = 1'b0;
      case (state_q)
        ST_SHIR: begin
          tdo_d    = ir_sr_q[0];
          tdo_oe_d = 1'b1;
        end
        ST_SHDR: begin
          tdo_d    = dr_sr_q[0];
          tdo_oe_d = 1'b1;
        end
        ST_UPDIR: ir_d = ir_sr_q;
        ST_UPDDR: begin
          if (is_user) begin
            user_data_d = dr_sr_q[7:0];
            user_stb_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (state_q == ST_TLR) ir_d = IR_LEN'(OPC_IDCODE);

`ifdef JTAG_TAP_NTRST_EN
    if (!ntrst_s) begin
      state_d  = ST_TLR;
      ir_d     = IR_LEN'(OPC_IDCODE);
      tdo_oe_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_TLR;
      ir_q        <= IR_LEN'(OPC_IDCODE);
      ir_sr_q     <= '0;
      dr_sr_q     <= '0;
      tdo_q       <= 1'b0;
      tdo_oe_q    <= 1'b0;
      user_data_q <= '0;
      user_stb_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      ir_sr_q     <= ir_sr_d;
      dr_sr_q     <= dr_sr_d;
      tdo_q       <= tdo_d;
      tdo_oe_q    <= tdo_oe_d;
      user_data_q <= user_data_d;
      user_stb_q  <= user_stb_d;
    end
  end

  assign TDO              = tdo_q;
  assign TDO_OE           = tdo_oe_q;
  assign TAP_STATE        = state_q;
  assign USER_UPDATE_DATA = user_data_q;
  assign USER_UPDATE_STB  = user_stb_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Randomized and directed bench for jtag_tap_responder against a bit-level TAP reference model.
module tb_jtag_tap_responder;
  import jtag_tap_pkg::*;

  localparam int          IR_LEN = 4;
  localparam logic [31:0] IDV    = 32'h1BB5_0093;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       TCK = 1'b0;
  logic       TMS = 1'b1;
  logic       TDI = 1'b0;
  logic [7:0] ucap = 8'h00;
  logic       tdo, tdo_oe, ustb;
  logic [3:0] tap_state;
  logic [7:0] udata;
`ifdef JTAG_TAP_NTRST_EN
  logic       ntrst = 1'b1;
`endif

  always #5 CLK = ~CLK;

  jtag_tap_responder dut (
    .CLK               (CLK),
    .RST               (RST),
`ifdef JTAG_TAP_NTRST_EN
    .nTRST             (ntrst),
`endif
    .TCK               (TCK),
    .TMS               (TMS),
    .TDI               (TDI),
    .TDO               (tdo),
    .TDO_OE            (tdo_oe),
    .TAP_STATE         (tap_state),
    .USER_CAPTURE_DATA (ucap),
    .USER_UPDATE_DATA  (udata),
    .USER_UPDATE_STB   (ustb)
  );

  int checks   = 0;
  int failures = 0;
  int stb_total = 0;
  logic last_tdo;

  always @(negedge CLK) if (ustb) stb_total++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: 1149.1 arcs as a table, registers as plain integers.
  logic [3:0] nxt [16][2];
  logic [3:0] m_state;
  int         m_ir, m_ir_sr, m_len, m_stb;
  logic [31:0] m_dr;
  logic       m_tdo, m_oe;
  logic [7:0] m_user;

  task automatic arc(input logic [3:0] s, input logic [3:0] on0, input logic [3:0] on1);
    nxt[s][0] = on0;
    nxt[s][1] = on1;
  endtask

  task automatic build_table();
    arc(ST_TLR,     ST_RTI,     ST_TLR);
    arc(ST_RTI,     ST_RTI,     ST_SELDR);
    arc(ST_SELDR,   ST_CAPDR,   ST_SELIR);
    arc(ST_CAPDR,   ST_SHDR,    ST_EX1DR);
    arc(ST_SHDR,    ST_SHDR,    ST_EX1DR);
    arc(ST_EX1DR,   ST_PAUSEDR, ST_UPDDR);
    arc(ST_PAUSEDR, ST_PAUSEDR, ST_EX2DR);
    arc(ST_EX2DR,   ST_SHDR,    ST_UPDDR);
    arc(ST_UPDDR,   ST_RTI,     ST_SELDR);
    arc(ST_SELIR,   ST_CAPIR,   ST_TLR);
    arc(ST_CAPIR,   ST_SHIR,    ST_EX1IR);
    arc(ST_SHIR,    ST_SHIR,    ST_EX1IR);
    arc(ST_EX1IR,   ST_PAUSEIR, ST_UPDIR);
    arc(ST_PAUSEIR, ST_PAUSEIR, ST_EX2IR);
    arc(ST_EX2IR,   ST_SHIR,    ST_UPDIR);
    arc(ST_UPDIR,   ST_RTI,     ST_SELDR);
  endtask

  task automatic model_reset();
    m_state = ST_TLR; m_ir = 1; m_ir_sr = 0; m_len = 1;
    m_dr = 0; m_tdo = 1'b0; m_oe = 1'b0; m_user = 8'h00; m_stb = 0;
  endtask

  task automatic model_rise(input logic tms, input logic tdi);
    if (m_state == ST_CAPIR) m_ir_sr = 1;
    else if (m_state == ST_SHIR) m_ir_sr = (m_ir_sr >> 1) | (int'(tdi) << (IR_LEN - 1));
    else if (m_state == ST_CAPDR) begin
      if (m_ir == 1)      begin m_dr = IDV;          m_len = 32; end
      else if (m_ir == 2) begin m_dr = 32'(ucap);    m_len = 8;  end
      else                begin m_dr = 0;            m_len = 1;  end
    end else if (m_state == ST_SHDR)
      m_dr = (m_dr >> 1) | (32'(tdi) << (m_len - 1));
    m_state = nxt[m_state][tms];
    if (m_state == ST_TLR) m_ir = 1;
  endtask

  task automatic model_fall();
    m_stb = 0;
    m_oe  = 1'b0;
    if (m_state == ST_SHIR) begin m_tdo = m_ir_sr[0]; m_oe = 1'b1; end
    else if (m_state == ST_SHDR) begin m_tdo = m_dr[0]; m_oe = 1'b1; end
    else if (m_state == ST_UPDIR) m_ir = m_ir_sr;
    else if (m_state == ST_UPDDR && m_ir == 2) begin m_user = m_dr[7:0]; m_stb = 1; end
  endtask

  // One full TCK period (4 CLK low, 4 high, 5 low) with per-bit checks against the model.
  task automatic tck_bit(input logic tms, input logic tdi);
    int s0;
    TMS = tms; TDI = tdi;
    repeat (4) @(negedge CLK);
    TCK = 1'b1;
    model_rise(tms, tdi);
    repeat (4) @(negedge CLK);
    check_eq("state", 32'(tap_state), 32'(m_state));
    s0 = stb_total;
    TCK = 1'b0;
    model_fall();
    repeat (5) @(negedge CLK);
    check_eq("tdo_oe", 32'(tdo_oe), 32'(m_oe));
    check_eq("tdo", 32'(tdo), 32'(m_tdo));
    check_eq("user_data", 32'(udata), 32'(m_user));
    check_eq("user_stb", 32'(stb_total - s0), 32'(m_stb));
    last_tdo = tdo;
  endtask

  task automatic go(input string p);
    for (int i = 0; i < p.len(); i++) tck_bit(p[i] == "1", 1'b0);
  endtask

  // Enter with the first shifted-out bit already on TDO; leaves in Exit1.
  task automatic shift_bits(input int n, input logic [63:0] din, output logic [63:0] dout);
    dout = '0;
    dout[0] = last_tdo;
    for (int i = 0; i < n; i++) begin
      tck_bit(i == n - 1, din[i]);
      if (i < n - 1) dout[i+1] = last_tdo;
    end
  endtask

  task automatic load_ir(input logic [IR_LEN-1:0] op);
    logic [63:0] d;
    go("1100");
    shift_bits(IR_LEN, 64'(op), d);
    go("10");
  endtask

  task automatic read_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
    go("100");
    shift_bits(n, din, dout);
    go("10");
  endtask

  task automatic pulse_rst();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    TCK = 1'b0;
    model_reset();
    repeat (6) @(negedge CLK);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    logic [IR_LEN-1:0] bypass_op;
    int s0;
    build_table();
    model_reset();
    bypass_op = IR_LEN'(OPC_BYPASS);

    @(negedge CLK);
    pulse_rst();
    check_eq("rst_state", 32'(tap_state), 32'(ST_TLR));
    check_eq("rst_oe", 32'(tdo_oe), 32'h0);
    check_eq("rst_tdo", 32'(tdo), 32'h0);
    check_eq("rst_udata", 32'(udata), 32'h0);
    check_eq("rst_stb", 32'(ustb), 32'h0);
    for (int i = 0; i < 5; i++) tck_bit(1'b1, 1'b0);

    // IDCODE read straight out of reset.
    go("0");
    read_dr(32, 64'h0, d);
    check_eq("idcode", d[31:0], 32'h1BB5_0093);

    // BYPASS: 9 bits in, TDO is TDI delayed one TCK behind a captured 0.
    load_ir(bypass_op);
    read_dr(9, 64'h1A5, d);
    check_eq("bypass_echo", 32'(d[8:0]), 32'h14A);

    // USER capture/update.
    ucap = 8'h3C;
    load_ir(IR_LEN'(OPC_USER));
    s0 = stb_total;
    read_dr(8, 64'hC3, d);
    check_eq("user_read", 32'(d[7:0]), 32'h3C);
    check_eq("user_update", 32'(udata), 32'hC3);
    check_eq("user_stb_once", 32'(stb_total - s0), 32'h1);

    // IR capture pattern 01, then unassigned opcode 7 acts as BYPASS.
    go("1100");
    shift_bits(IR_LEN, 64'h7, d);
    go("10");
    check_eq("ir_capture", 32'(d[1:0]), 32'h1);
    read_dr(3, 64'h5, d);
    check_eq("opc7_bypass", 32'(d[2:0]), 32'h2);

    // Random TMS/TDI walks under several instructions.
    for (int r = 0; r < 4; r++) begin
      go("11111");
      go("0");
      case (r)
        0: load_ir(IR_LEN'(OPC_USER));
        1: load_ir(IR_LEN'(OPC_IDCODE));
        2: load_ir(IR_LEN'($urandom_range(0, (1 << IR_LEN) - 1)));
        default: load_ir(bypass_op);
      endcase
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, 15) == 0) ucap = 8'($urandom);
        tck_bit($urandom_range(0, 99) < 30, 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 5; i++) tck_bit(1'b1, 1'($urandom_range(0, 1)));
      check_eq("tlr_after_5", 32'(tap_state), 32'(ST_TLR));
    end

    // RST while the 10th USER bit is in flight: no update, TAP back in TLR with IDCODE.
    go("0");
    load_ir(IR_LEN'(OPC_USER));
    go("100");
    for (int i = 0; i < 9; i++) tck_bit(1'b0, 1'($urandom_range(0, 1)));
    s0 = stb_total;
    TMS = 1'b0; TDI = 1'b1;
    repeat (4) @(negedge CLK);
    TCK = 1'b1;
    @(negedge CLK);
    pulse_rst();
    check_eq("rst_mid_state", 32'(tap_state), 32'(ST_TLR));
    check_eq("rst_mid_oe", 32'(tdo_oe), 32'h0);
    check_eq("rst_mid_stb", 32'(stb_total - s0), 32'h0);
    go("0");
    read_dr(32, 64'h0, d);
    check_eq("rst_mid_idcode", d[31:0], IDV);

`ifdef JTAG_TAP_NTRST_EN
    load_ir(IR_LEN'(OPC_USER));
    go("100");
    for (int i = 0; i < 9; i++) tck_bit(1'b0, 1'($urandom_range(0, 1)));
    s0 = stb_total;
    ntrst = 1'b0;
    repeat (6) @(negedge CLK);
    m_state = ST_TLR; m_ir = 1; m_oe = 1'b0;
    check_eq("ntrst_state", 32'(tap_state), 32'(ST_TLR));
    check_eq("ntrst_oe", 32'(tdo_oe), 32'h0);
    check_eq("ntrst_stb", 32'(stb_total - s0), 32'h0);
    ntrst = 1'b1;
    repeat (4) @(negedge CLK);
    go("0");
    read_dr(32, 64'h0, d);
    check_eq("ntrst_idcode", d[31:0], IDV);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
